// File: rtl/planificador_emisor_pkg.sv
// Shared constants and types for the four-channel frame transmit scheduler.
// Slot numbering, line levels and FSM encoding live here.
package planificador_emisor_pkg;

  localparam int FRAME_SLOTS = 13;

  localparam logic [3:0] SLOT_START = 4'd0;
  localparam logic [3:0] SLOT_PAR   = 4'd9;
  localparam logic [3:0] SLOT_LAST  = 4'(FRAME_SLOTS - 1);

  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } estado_t;

  function automatic logic [1:0] siguienteCanal(input logic [1:0] c);
    return c + 2'd1;
  endfunction

endpackage

// File: rtl/generador_baudios.sv
// Clearable bit-rate divider: one-cycle oTick every DIVISOR cycles.
// Held at zero while iClear is high so the first slot is full length.
module generador_baudios #(
  parameter int DIVISOR = 434
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iClear,
  output logic oTick
);

  localparam int CNT_W = $clog2(DIVISOR + 1);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt;

  assign oTick = !iClear && (cnt == ULTIMO);

  always_ff @(posedge iClk) begin
    if (iReset || iClear) begin
      cnt <= '0;
    end else if (oTick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/planificador_emisor.sv
// Round-robin arbiter for four byte requesters sharing one frame serializer.
// Frame: start high, 8 data LSB-first, even parity, 3 low stop slots.
module planificador_emisor
  import planificador_emisor_pkg::*;
#(
  parameter int DIVISOR = 434
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic [3:0] ivReq,
  input  logic [7:0] ivDato0,
  input  logic [7:0] ivDato1,
  input  logic [7:0] ivDato2,
  input  logic [7:0] ivDato3,
  output logic [3:0] ovAck,
  output logic [1:0] ovGrant,
  output logic       oBusy,
  output logic       oDato
);

  estado_t    estado, estadoSig;
  logic [1:0] puntero, ganador, idx;
  logic       hay, cargar, tick;
  logic [3:0] slot;
  logic [7:0] dato, datoSel;
  logic       paridad;
  logic [2:0] bitIdx;

  generador_baudios #(.DIVISOR(DIVISOR)) uBaud (
    .iClk  (iClk),
    .iReset(iReset),
    .iClear(estado == IDLE),
    .oTick (tick)
  );

  // First requester found scanning upward from the pointer, wrapping mod 4
  always_comb begin
    ganador = puntero;
    hay     = 1'b0;
    idx     = puntero;
    for (int k = 0; k < 4; k++) begin
      idx = puntero + 2'(k);
      if (!hay && ivReq[idx]) begin
        ganador = idx;
        hay     = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (ganador)
      2'd0: datoSel = ivDato0;
      2'd1: datoSel = ivDato1;
      2'd2: datoSel = ivDato2;
      2'd3: datoSel = ivDato3;
    endcase
  end

  always_comb begin
    estadoSig = estado;
    cargar    = 1'b0;
    unique case (estado)
      IDLE: begin
        if (hay) begin
          estadoSig = SEND;
          cargar    = 1'b1;
        end
      end
      SEND: begin
        if (tick && slot == SLOT_LAST) estadoSig = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) estado <= IDLE;
    else        estado <= estadoSig;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      puntero <= '0;
      ovAck   <= '0;
      ovGrant <= '0;
      slot    <= SLOT_START;
      dato    <= '0;
      paridad <= 1'b0;
    end else begin
      ovAck <= '0;
      if (cargar) begin
        ovAck   <= 4'b0001 << ganador;
        ovGrant <= ganador;
        puntero <= siguienteCanal(ganador);
        dato    <= datoSel;
        paridad <= ^datoSel;
        slot    <= SLOT_START;
      end else if (estado == SEND && tick && slot != SLOT_LAST) begin
        slot <= slot + 4'd1;
      end
    end
  end

  assign oBusy  = (estado == SEND);
  assign bitIdx = 3'(slot - 4'd1);

  always_comb begin
    oDato = LINE_IDLE;
    if (estado == SEND) begin
      if (slot == SLOT_START)   oDato = LINE_START;
      else if (slot < SLOT_PAR) oDato = dato[bitIdx];
      else if (slot == SLOT_PAR) oDato = paridad;
    end
  end

endmodule

// File: tb/tb_planificador_emisor.sv
// Scoreboard bench: stimulus queues expected frames, a monitor checks them.
// Reference model is round-robin pick plus frame assembly from the byte.
module tb_planificador_emisor;

  localparam int DIVISOR = 4;
  localparam int FRAME_CYC = 13 * DIVISOR;

  logic       iClk = 1'b0;
  logic       iReset;
  logic [3:0] ivReq;
  logic [7:0] dat [4];
  logic [7:0] ivDato0, ivDato1, ivDato2, ivDato3;
  logic [3:0] ovAck;
  logic [1:0] ovGrant;
  logic       oBusy, oDato;

  assign ivDato0 = dat[0];
  assign ivDato1 = dat[1];
  assign ivDato2 = dat[2];
  assign ivDato3 = dat[3];

  planificador_emisor #(.DIVISOR(DIVISOR)) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .ivReq  (ivReq),
    .ivDato0(ivDato0),
    .ivDato1(ivDato1),
    .ivDato2(ivDato2),
    .ivDato3(ivDato3),
    .ovAck  (ovAck),
    .ovGrant(ovGrant),
    .oBusy  (oBusy),
    .oDato  (oDato)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          chan;
    logic [12:0] frame;
  } esperado_t;

  esperado_t q[$];
  int errors = 0;
  int checks = 0;
  int ackCount = 0;
  int framesDone = 0;
  int modelP = 0;

  task automatic chk(input string nombre, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, req, $time);
    end
  endtask

  task automatic failNow(input string nombre);
    checks++;
    errors++;
    $display("FAIL %s: timeout at %0t", nombre, $time);
  endtask

  function automatic int pick(input logic [3:0] mask, input int p);
    for (int k = 0; k < 4; k++) begin
      if (mask[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [12:0] mkFrame(input logic [7:0] d);
    logic [12:0] f;
    f = '0;
    f[0] = 1'b1;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    f[9] = ^d;
    return f;
  endfunction

  function automatic void expect_(input logic [3:0] mask);
    esperado_t e;
    int w;
    w = pick(mask, modelP);
    e.chan = w;
    e.frame = mkFrame(dat[w]);
    q.push_back(e);
    modelP = (w + 1) % 4;
  endfunction

  // Monitor: every ack pops one expected frame and checks it slot by slot
  initial begin
    esperado_t e;
    bit abortado;
    forever begin
      @(negedge iClk);
      if (ovAck !== 4'b0000) begin
        ackCount++;
        if (q.size() == 0) begin
          chk("unexpected_ack", {28'b0, ovAck}, 32'h0);
        end else begin
          e = q.pop_front();
          chk("ack", {28'b0, ovAck}, 32'(4'b0001 << e.chan));
          chk("grant", {30'b0, ovGrant}, 32'(e.chan));
          abortado = 1'b0;
          for (int s = 0; s < 13 && !abortado; s++) begin
            for (int c = 0; c < DIVISOR && !abortado; c++) begin
              if (!(s == 0 && c == 0)) begin
                @(negedge iClk);
                chk("ack_in_send", {28'b0, ovAck}, 32'h0);
              end
              chk($sformatf("dato_slot%0d", s), {31'b0, oDato},
                  {31'b0, e.frame[s]});
              chk("busy", {31'b0, oBusy}, 32'h1);
              if (iReset) abortado = 1'b1;
            end
          end
          if (!abortado) begin
            @(negedge iClk);
            chk("idle_busy", {31'b0, oBusy}, 32'h0);
            chk("idle_dato", {31'b0, oDato}, 32'h0);
            framesDone++;
          end
        end
      end
    end
  end

  task automatic waitAck();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge iClk);
      if (ovAck !== 4'b0000) ok = 1'b1;
    end
    if (!ok) failNow("wait_ack");
  endtask

  task automatic waitFrames(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge iClk);
      if (framesDone >= target) ok = 1'b1;
    end
    if (!ok) failNow("wait_frame");
  endtask

  task automatic issue(input logic [3:0] mask, input bit scramble);
    int fd;
    fd = framesDone;
    @(posedge iClk); #1;
    expect_(mask);
    ivReq = mask;
    waitAck();
    @(posedge iClk); #1;
    ivReq = 4'b0000;
    if (scramble) begin
      for (int i = 0; i < 4; i++) dat[i] = ~dat[i];
    end
    waitFrames(fd + 1, FRAME_CYC + 10);
  endtask

  initial begin
    int base, fd;
    iReset = 1'b1;
    ivReq = 4'b0000;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    repeat (3) @(posedge iClk);
    #1;
    iReset = 1'b0;
    @(negedge iClk);
    chk("rst_ack", {28'b0, ovAck}, 32'h0);
    chk("rst_grant", {30'b0, ovGrant}, 32'h0);
    chk("rst_busy", {31'b0, oBusy}, 32'h0);
    chk("rst_dato", {31'b0, oDato}, 32'h0);

    // Fairness: all four held, service order 0,1,2,3,0
    for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);
    base = ackCount;
    fd = framesDone;
    @(posedge iClk); #1;
    for (int i = 0; i < 5; i++) expect_(4'b1111);
    ivReq = 4'b1111;
    for (int i = 0; i < 5 * (FRAME_CYC + 1) + 20 && ackCount < base + 5; i++)
      @(negedge iClk);
    if (ackCount < base + 5) failNow("fair_acks");
    @(posedge iClk); #1;
    ivReq = 4'b0000;
    waitFrames(fd + 5, FRAME_CYC + 10);

    // Pointer rotation: serve ch2, then 0101 must go to ch0
    dat[2] = 8'h3C;
    issue(4'b0100, 1'b0);
    dat[0] = 8'h5A;
    dat[2] = 8'hC3;
    issue(4'b0101, 1'b0);

    dat[0] = 8'hA5;
    issue(4'b0001, 1'b0);
    dat[0] = 8'h01;
    issue(4'b0001, 1'b0);
    dat[0] = 8'hFF;
    issue(4'b0001, 1'b0);

    // Late data change after capture
    dat[0] = 8'h96;
    issue(4'b0001, 1'b1);

    // Reset in slot 5 of a ch2 frame
    dat[2] = 8'h77;
    @(posedge iClk); #1;
    expect_(4'b0100);
    ivReq = 4'b0100;
    waitAck();
    repeat (5 * DIVISOR + 1) @(negedge iClk);
    @(posedge iClk); #1;
    ivReq = 4'b0000;
    iReset = 1'b1;
    @(posedge iClk); #1;
    iReset = 1'b0;
    modelP = 0;
    @(negedge iClk);
    chk("mid_rst_dato", {31'b0, oDato}, 32'h0);
    chk("mid_rst_busy", {31'b0, oBusy}, 32'h0);
    chk("mid_rst_grant", {30'b0, ovGrant}, 32'h0);
    dat[3] = 8'hE1;
    issue(4'b1000, 1'b0);
    dat[0] = 8'h42;
    dat[3] = 8'h24;
    issue(4'b1001, 1'b0);

    // Reset beats a simultaneous request
    @(posedge iClk); #1;
    iReset = 1'b1;
    ivReq = 4'b0001;
    @(posedge iClk); #1;
    iReset = 1'b0;
    ivReq = 4'b0000;
    modelP = 0;
    @(negedge iClk);
    chk("rst_prio_ack", {28'b0, ovAck}, 32'h0);
    chk("rst_prio_busy", {31'b0, oBusy}, 32'h0);

    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      issue(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge iClk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
